// File: rtl/combo_sweeper_if.sv
// Bundle of signals between the combination sweeper (master side) and
// the combination lock plus its controlling host (slave side).
interface combo_sweeper_if;
    logic       start;
    logic       lock_open;
    logic       lock_fail;
    logic [3:0] combo;
    logic       enter;
    logic       busy;
    logic       done;
    logic       found;
    logic [3:0] found_combo;
    logic [4:0] attempts;

    modport master (
        input  start, lock_open, lock_fail,
        output combo, enter, busy, done, found, found_combo, attempts
    );

    modport slave (
        output start, lock_open, lock_fail,
        input  combo, enter, busy, done, found, found_combo, attempts
    );
endinterface

// File: rtl/combo_sweeper.sv
// Automatic entry sequencer for the combination lock. Presents combos
// 0..15 in turn, pulses enter, and waits for the lock's verdict. Stops on
// the first combination that opens the lock or after all 16 have failed.
// Every output comes straight from a flop. SETTLE_CYC, ENTER_HIGH and
// TIMEOUT must each be at least 1.
module combo_sweeper #(
    parameter int SETTLE_CYC = 4,
    parameter int ENTER_HIGH = 3,
    parameter int TIMEOUT    = 16
) (
    input  logic                   Clock,
    input  logic                   Resetn,
    combo_sweeper_if.master        bus
);

    localparam int MAX_A = (SETTLE_CYC > ENTER_HIGH) ? SETTLE_CYC : ENTER_HIGH;
    localparam int MAX_P = (MAX_A > TIMEOUT) ? MAX_A : TIMEOUT;
    // The counter only ever reaches MAX_P-1 before it is cleared.
    localparam int CW    = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] ENTER_LAST   = CW'(ENTER_HIGH - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      combo_q, combo_d;
    logic            enter_q, enter_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            found_q, found_d;
    logic [3:0]      found_combo_q, found_combo_d;
    logic [4:0]      attempts_q, attempts_d;
    logic            resolve;

    // Next-state and next-output logic for the sweep sequencer.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the
        // case leaves one unassigned, which would infer a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        combo_d       = combo_q;
        busy_d        = busy_q;
        done_d        = done_q;
        found_d       = found_q;
        found_combo_d = found_combo_q;
        attempts_d    = attempts_q;
        resolve       = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d       = S_SETUP;
                    cnt_d         = '0;
                    combo_d       = 4'd0;
                    attempts_d    = 5'd0;
                    done_d        = 1'b0;
                    found_d       = 1'b0;
                    found_combo_d = 4'd0;
                    busy_d        = 1'b1;
                end
            end
            S_SETUP: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d    = S_PULSE;
                    cnt_d      = '0;
                    attempts_d = attempts_q + 5'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_PULSE: begin
                // An early verdict is honoured exactly as it would be in WAIT.
                if (bus.lock_open || bus.lock_fail) begin
                    resolve = 1'b1;
                end else if (cnt_q == ENTER_LAST) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT: begin
                // A silent lock is treated as a rejection once TIMEOUT expires.
                if (bus.lock_open || bus.lock_fail || cnt_q == TIMEOUT_LAST) begin
                    resolve = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (resolve) begin
            cnt_d = '0;
            if (bus.lock_open) begin
                // Open wins when both verdicts arrive together.
                state_d       = S_DONE;
                found_d       = 1'b1;
                found_combo_d = combo_q;
                done_d        = 1'b1;
                busy_d        = 1'b0;
            end else if (combo_q == 4'd15) begin
                state_d = S_DONE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end else begin
                state_d = S_SETUP;
                combo_d = combo_q + 4'd1;
            end
        end

        // Registering enter from the next state keeps it high for exactly
        // the cycles spent in PULSE, with no input-to-output path.
        enter_d = (state_d == S_PULSE);
    end

    // State and output registers; reset aborts a sweep and drops enter at once.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            combo_q       <= 4'd0;
            enter_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            found_q       <= 1'b0;
            found_combo_q <= 4'd0;
            attempts_q    <= 5'd0;
        end else begin
            // NOTE: non-blocking assignments so every flop updates from the
            // values present before the edge.
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            combo_q       <= combo_d;
            enter_q       <= enter_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            found_q       <= found_d;
            found_combo_q <= found_combo_d;
            attempts_q    <= attempts_d;
        end
    end

    assign bus.combo       = combo_q;
    assign bus.enter       = enter_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.found       = found_q;
    assign bus.found_combo = found_combo_q;
    assign bus.attempts    = attempts_q;

endmodule
